// File: rtl/clk_gen_ctrl_if.sv
// Control/status bundle between a sequencer client and the divided-clock controller.
// The client drives start/stop/mask; the controller returns the gated clocks and status.
interface clk_gen_ctrl_if #(
    parameter int N_CLKS = 3
);
    logic              start;
    logic              stop;
    logic [N_CLKS-1:0] mask;
    logic [N_CLKS-1:0] clks;
    logic [N_CLKS-1:0] en;
    logic              ready;
    logic              busy;

    modport master (
        output start, stop, mask,
        input  clks, en, ready, busy
    );

    modport slave (
        input  start, stop, mask,
        output clks, en, ready, busy
    );
endinterface

// File: rtl/clk_gen_ctrl.sv
// Divided-clock sequencer: one shared counter yields clk/2..clk/2^N_CLKS, enabled one
// per frame on start, held for a lock interval before ready, and torn down high-to-low on stop.
module clk_gen_ctrl #(
    parameter int N_CLKS       = 3,
    parameter int LOCK_PERIODS = 2
) (
    input  logic          clk,
    input  logic          reset,
    clk_gen_ctrl_if.slave bus
);
    localparam int LW = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LOCK  = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [N_CLKS-1:0] cnt_q, cnt_d;
    logic [N_CLKS-1:0] en_q, en_d;
    logic [N_CLKS-1:0] mask_q, mask_d;
    logic [N_CLKS-1:0] clks_q, clks_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              boundary_s;
    logic [N_CLKS-1:0] grow_s;
    logic [N_CLKS-1:0] shrink_s;

    function automatic logic [N_CLKS-1:0] lowest_bit(input logic [N_CLKS-1:0] v);
        logic [N_CLKS-1:0] r;
        logic              found;
        r     = {N_CLKS{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N_CLKS; i++) begin
            r[i]  = v[i] & ~found;
            found = found | v[i];
        end
        return r;
    endfunction

    function automatic logic [N_CLKS-1:0] highest_bit(input logic [N_CLKS-1:0] v);
        logic [N_CLKS-1:0] r;
        logic              found;
        r     = {N_CLKS{1'b0}};
        found = 1'b0;
        for (int i = N_CLKS - 1; i >= 0; i--) begin
            r[i]  = v[i] & ~found;
            found = found | v[i];
        end
        return r;
    endfunction

    // Next-state logic; en only moves on a frame boundary, where every divided clock is about to fall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + N_CLKS'(1);
        en_d       = en_q;
        mask_d     = mask_q;
        lock_cnt_d = lock_cnt_q;
        boundary_s = (cnt_q == {N_CLKS{1'b1}});
        grow_s     = en_q | lowest_bit(mask_q & ~en_q);
        shrink_s   = en_q & ~highest_bit(en_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop && (bus.mask != {N_CLKS{1'b0}})) begin
                    mask_d  = bus.mask;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bus.stop) begin
                    state_d = S_STOP;
                end else if (boundary_s) begin
                    en_d = grow_s;
                    if (grow_s == mask_q) begin
                        state_d    = S_LOCK;
                        lock_cnt_d = {LW{1'b0}};
                    end else begin
                        state_d = S_START;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_LOCK: begin
                if (bus.stop) begin
                    state_d = S_STOP;
                end else if (boundary_s) begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                    if ((lock_cnt_q + LW'(1)) == LW'(LOCK_PERIODS)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_LOCK;
                    end
                end else begin
                    state_d = S_LOCK;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_STOP: begin
                if (en_q == {N_CLKS{1'b0}}) begin
                    state_d = S_IDLE;
                end else if (boundary_s) begin
                    en_d = shrink_s;
                    if (shrink_s == {N_CLKS{1'b0}}) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = {N_CLKS{1'b0}};
            end
        endcase

        // Gating against next-cycle values keeps a freshly enabled clock starting low.
        clks_d  = cnt_d & en_d;
        busy_d  = (state_d == S_START) || (state_d == S_LOCK) || (state_d == S_STOP);
        ready_d = (state_d == S_RUN);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {N_CLKS{1'b0}};
            en_q       <= {N_CLKS{1'b0}};
            mask_q     <= {N_CLKS{1'b0}};
            clks_q     <= {N_CLKS{1'b0}};
            lock_cnt_q <= {LW{1'b0}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            mask_q     <= mask_d;
            clks_q     <= clks_d;
            lock_cnt_q <= lock_cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.clks  = clks_q;
    assign bus.en    = en_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
endmodule
